control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 37 +++
 rtl/control_unit.sv | 214 +++++++++++++++++++++
 tb/tb_control_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_if
// Description : Bundle of the signals between the control sequencer and the
//               datapath. Inputs to the sequencer: IR, Run, mem_ready.
//               Outputs from the sequencer: the 15 datapath strobes, Rout and
//               Rin (one-hot register enables), ALU select and halted.
//               master = control unit side, slave = datapath side.
// Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
  logic [31:0] IR;
  logic        Run;
  logic        mem_ready;

  logic        PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin;
  logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [4:0]  ALU;
  logic        halted;

  modport master (
    input  IR, Run, mem_ready,
    output PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin,
           Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
           Rout, Rin, ALU, halted
  );

  modport slave (
    output IR, Run, mem_ready,
    input  PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin,
           Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
           Rout, Rin, ALU, halted
  );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Moore-style instruction sequencer (T0..T6, HALT) that drives
//               the datapath strobes for fetch, R-type ALU ops, MUL/DIV and
//               HALT. All other opcodes behave as NOP.
// Ports       : clock - system clock, rising edge
//               clear - synchronous active-low reset
//               bus   - control_unit_if.master (IR, Run, mem_ready in;
//                       strobes, Rout, Rin, ALU, halted out)
// Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
  parameter logic [4:0] ROR_ALU = 5'b01000,
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  wire logic      clock,
  input  wire logic      clear,
  control_unit_if.master bus
);

  localparam logic [4:0] OP_ROR   = 5'b01010;
  localparam logic [4:0] OP_RMAX  = 5'b01100;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in, rd, mdr_in, mdr_out, ir_in;
    logic y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
  } ctl_t;

  state_t     state_q, state_d;
  logic       pc_done_q, pc_done_d;   // PCin already issued in this T1 visit
  logic [4:0] opcode_q, opcode_d;
  logic [3:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [4:0] alu_q, alu_d;

  ctl_t        ctl;
  logic [15:0] rout_raw, rin_raw;
  logic        alu_load;
  logic [4:0]  alu_code;
  logic        drive;
  logic        is_halt, is_rtype, is_muldiv;
  logic        unused_ir_bits;

  // Low IR bits carry immediates the sequencer never looks at.
  assign unused_ir_bits = ^bus.IR[14:0];

  // Strobes are only issued while running and not being cleared, so a clear
  // landing on T5 never lets the register write escape.
  assign drive = bus.Run & clear;

  assign is_halt   = (opcode_q == HALT_OP);
  assign is_rtype  = !is_halt && (opcode_q <= OP_RMAX);
  assign is_muldiv = !is_halt && ((opcode_q == OP_MUL) || (opcode_q == OP_DIV));

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= T0;
      pc_done_q <= 1'b0;
      opcode_q  <= 5'd0;
      ra_q      <= 4'd0;
      rb_q      <= 4'd0;
      rc_q      <= 4'd0;
      alu_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      pc_done_q <= pc_done_d;
      opcode_q  <= opcode_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      alu_q     <= alu_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_done_d = pc_done_q;
    opcode_d  = opcode_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    ctl       = '0;
    rout_raw  = 16'h0000;
    rin_raw   = 16'h0000;
    alu_load  = 1'b0;
    alu_code  = 5'd0;

    case (state_q)
      T0: begin
        ctl.pc_out  = 1'b1;
        ctl.mar_in  = 1'b1;
        ctl.inc_pc  = 1'b1;
        ctl.zlow_in = 1'b1;
        if (bus.Run) begin
          state_d   = T1;
          pc_done_d = 1'b0;
        end
      end
      T1: begin
        ctl.zlow_out = 1'b1;
        ctl.pc_in    = !pc_done_q;
        ctl.rd       = 1'b1;
        ctl.mdr_in   = 1'b1;
        if (bus.Run) begin
          if (bus.mem_ready) begin
            state_d   = T2;
            pc_done_d = 1'b0;
          end else begin
            pc_done_d = 1'b1;
          end
        end
      end
      T2: begin
        ctl.mdr_out = 1'b1;
        ctl.ir_in   = 1'b1;
        if (bus.Run) begin
          state_d  = T3;
          opcode_d = bus.IR[31:27];
          ra_d     = bus.IR[26:23];
          rb_d     = bus.IR[22:19];
          rc_d     = bus.IR[18:15];
        end
      end
      T3: begin
        if (is_rtype) begin
          rout_raw = 16'h0001 << rb_q;
          ctl.y_in = 1'b1;
        end else if (is_muldiv) begin
          rout_raw = 16'h0001 << ra_q;
          ctl.y_in = 1'b1;
        end
        if (bus.Run) begin
          if (is_halt)                     state_d = HALT;
          else if (is_rtype || is_muldiv)  state_d = T4;
          else                             state_d = T0;
        end
      end
      T4: begin
        if (is_rtype) begin
          rout_raw    = 16'h0001 << rc_q;
          ctl.zlow_in = 1'b1;
          alu_load    = 1'b1;
          alu_code    = (opcode_q == OP_ROR) ? ROR_ALU : opcode_q;
        end else if (is_muldiv) begin
          rout_raw     = 16'h0001 << rb_q;
          ctl.zlow_in  = 1'b1;
          ctl.zhigh_in = 1'b1;
          alu_load     = 1'b1;
          alu_code     = opcode_q;
        end
        if (bus.Run) state_d = (is_rtype || is_muldiv) ? T5 : T0;
      end
      T5: begin
        if (is_rtype) begin
          ctl.zlow_out = 1'b1;
          rin_raw      = 16'h0001 << ra_q;
        end else if (is_muldiv) begin
          ctl.zlow_out = 1'b1;
          ctl.lo_in    = 1'b1;
        end
        if (bus.Run) state_d = is_muldiv ? T6 : T0;
      end
      T6: begin
        ctl.zhigh_out = 1'b1;
        ctl.hi_in     = 1'b1;
        if (bus.Run) state_d = T0;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

  // ALU select is remembered across cycles; it only changes in an active T4.
  assign alu_d = (bus.Run && alu_load) ? alu_code : alu_q;

  assign bus.PCout    = drive & ctl.pc_out;
  assign bus.MARin    = drive & ctl.mar_in;
  assign bus.IncPC    = drive & ctl.inc_pc;
  assign bus.PCin     = drive & ctl.pc_in;
  assign bus.read     = drive & ctl.rd;
  assign bus.MDRin    = drive & ctl.mdr_in;
  assign bus.MDRout   = drive & ctl.mdr_out;
  assign bus.IRin     = drive & ctl.ir_in;
  assign bus.Yin      = drive & ctl.y_in;
  assign bus.Zlowin   = drive & ctl.zlow_in;
  assign bus.Zhighin  = drive & ctl.zhigh_in;
  assign bus.Zlowout  = drive & ctl.zlow_out;
  assign bus.Zhighout = drive & ctl.zhigh_out;
  assign bus.HIin     = drive & ctl.hi_in;
  assign bus.LOin     = drive & ctl.lo_in;
  assign bus.Rout     = drive ? rout_raw : 16'h0000;
  assign bus.Rin      = drive ? rin_raw  : 16'h0000;
  assign bus.ALU      = (drive && alu_load) ? alu_code : alu_q;
  assign bus.halted   = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. A step-list reference
//               model (one entry per T-state of the current instruction,
//               built from the opcode rules) is compared on every negedge;
//               directed sequences pin literal values from worked examples.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

  localparam logic [4:0] ROR_ALU = 5'b01000;
  localparam logic [4:0] HALT_OP = 5'b11011;

  // Strobe vector bit positions (LSB first, in port-list order).
  localparam logic [14:0] M_PCOUT    = 15'h0001;
  localparam logic [14:0] M_MARIN    = 15'h0002;
  localparam logic [14:0] M_INCPC    = 15'h0004;
  localparam logic [14:0] M_PCIN     = 15'h0008;
  localparam logic [14:0] M_READ     = 15'h0010;
  localparam logic [14:0] M_MDRIN    = 15'h0020;
  localparam logic [14:0] M_MDROUT   = 15'h0040;
  localparam logic [14:0] M_IRIN     = 15'h0080;
  localparam logic [14:0] M_YIN      = 15'h0100;
  localparam logic [14:0] M_ZLOWIN   = 15'h0200;
  localparam logic [14:0] M_ZHIGHIN  = 15'h0400;
  localparam logic [14:0] M_ZLOWOUT  = 15'h0800;
  localparam logic [14:0] M_ZHIGHOUT = 15'h1000;
  localparam logic [14:0] M_HIIN     = 15'h2000;
  localparam logic [14:0] M_LOIN     = 15'h4000;

  typedef struct {
    logic [14:0] strb;
    logic [15:0] rout;
    logic [15:0] rin;
    bit          alu_drv;
    logic [4:0]  alu;
    bit          is_t1;
    bit          latch;
    bit          halt_after;
  } step_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  control_unit_if cu_if();

  control_unit #(.ROR_ALU(ROR_ALU), .HALT_OP(HALT_OP)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (cu_if)
  );

  logic [14:0] dut_strb;
  assign dut_strb = {cu_if.LOin, cu_if.HIin, cu_if.Zhighout, cu_if.Zlowout,
                     cu_if.Zhighin, cu_if.Zlowin, cu_if.Yin, cu_if.IRin,
                     cu_if.MDRout, cu_if.MDRin, cu_if.read, cu_if.PCin,
                     cu_if.IncPC, cu_if.MARin, cu_if.PCout};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  step_t      q[$];
  bit         m_valid = 1'b0;
  bit         m_halt  = 1'b0;
  bit         m_t1seen = 1'b0;
  logic [4:0] m_alu   = 5'd0;

  function automatic step_t mk(logic [14:0] s, logic [15:0] ro, logic [15:0] ri,
                               bit ad, logic [4:0] a, bit t1, bit lt, bit hl);
    step_t r;
    r.strb = s; r.rout = ro; r.rin = ri; r.alu_drv = ad; r.alu = a;
    r.is_t1 = t1; r.latch = lt; r.halt_after = hl;
    return r;
  endfunction

  task automatic push_fetch();
    q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 0, 0, 0, 0, 1, 0, 0));
    q.push_back(mk(M_MDROUT | M_IRIN, 0, 0, 0, 0, 0, 1, 0));
  endtask

  task automatic push_exec(input logic [31:0] ir);
    logic [4:0]  op;
    logic [15:0] ra, rb, rc;
    op = ir[31:27];
    ra = 16'd1 << ir[26:23];
    rb = 16'd1 << ir[22:19];
    rc = 16'd1 << ir[18:15];
    if (op == HALT_OP) begin
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    end else if (op <= 5'd12) begin
      q.push_back(mk(M_YIN, rb, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(M_ZLOWIN, rc, 0, 1, (op == 5'b01010) ? ROR_ALU : op, 0, 0, 0));
      q.push_back(mk(M_ZLOWOUT, 0, ra, 0, 0, 0, 0, 0));
    end else if (op == 5'd15 || op == 5'd16) begin
      q.push_back(mk(M_YIN, ra, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(M_ZLOWIN | M_ZHIGHIN, rb, 0, 1, op, 0, 0, 0));
      q.push_back(mk(M_ZLOWOUT | M_LOIN, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(M_ZHIGHOUT | M_HIIN, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  always @(posedge clock) begin : model_update
    step_t f;
    if (!clear) begin
      m_valid  = 1'b1;
      m_halt   = 1'b0;
      m_alu    = 5'd0;
      m_t1seen = 1'b0;
      q.delete();
      push_fetch();
    end else if (m_valid && !m_halt && cu_if.Run && q.size() > 0) begin
      f = q[0];
      if (f.alu_drv) m_alu = f.alu;
      if (f.is_t1 && !cu_if.mem_ready) begin
        m_t1seen = 1'b1;
      end else begin
        void'(q.pop_front());
        m_t1seen = 1'b0;
        if (f.latch) push_exec(cu_if.IR);
        if (f.halt_after) m_halt = 1'b1;
        else if (q.size() == 0) push_fetch();
      end
    end
  end

  always @(negedge clock) begin : compare
    step_t       f;
    logic [14:0] e_strb;
    logic [15:0] e_rout, e_rin;
    logic [4:0]  e_alu;
    int          n_drv;
    if (m_valid) begin
      e_strb = 0; e_rout = 0; e_rin = 0; e_alu = m_alu;
      if (clear && cu_if.Run && !m_halt && q.size() > 0) begin
        f = q[0];
        e_strb = f.strb;
        if (f.is_t1 && m_t1seen) e_strb = e_strb & ~M_PCIN;
        e_rout = f.rout;
        e_rin  = f.rin;
        if (f.alu_drv) e_alu = f.alu;
      end
      chk("strobes", dut_strb, e_strb);
      chk("rout", cu_if.Rout, e_rout);
      chk("rin", cu_if.Rin, e_rin);
      chk("alu", cu_if.ALU, e_alu);
      chk("halted", cu_if.halted, m_halt);
      n_drv = int'(cu_if.PCout) + int'(cu_if.MDRout) + int'(cu_if.Zlowout)
            + int'(cu_if.Zhighout) + $countones(cu_if.Rout);
      chk("bus_drivers_le1", (n_drv <= 1), 1);
      chk("rin_onehot0", $onehot0(cu_if.Rin), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [31:0] rnd;
  logic [4:0]  rop;

  initial begin
    cu_if.IR        = 32'h0;
    cu_if.Run       = 1'b0;
    cu_if.mem_ready = 1'b0;
    clear           = 1'b0;
    ticks(2);

    // Reset state.
    chk("rst_halted", cu_if.halted, 0);
    chk("rst_rout", cu_if.Rout, 0);
    chk("rst_alu", cu_if.ALU, 0);
    chk("rst_strobes", dut_strb, 0);

    // ROR R6,R6,R4 with immediate memory.
    clear = 1'b1; cu_if.Run = 1'b1; cu_if.mem_ready = 1'b1; cu_if.IR = 32'h53320000;
    #1;
    chk("ror_t0", dut_strb, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN);
    tick(); chk("ror_t1", dut_strb, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
    tick(); chk("ror_t2", dut_strb, M_MDROUT | M_IRIN);
    tick(); chk("ror_t3_rout", cu_if.Rout, 16'h0040); chk("ror_t3_yin", cu_if.Yin, 1);
    tick(); chk("ror_t4_rout", cu_if.Rout, 16'h0010); chk("ror_t4_alu", cu_if.ALU, 5'b01000);
            chk("ror_t4_zlowin", cu_if.Zlowin, 1);
    tick(); chk("ror_t5_rin", cu_if.Rin, 16'h0040); chk("ror_t5_zlowout", cu_if.Zlowout, 1);
    tick(); chk("ror_next_t0", cu_if.PCout, 1);

    // MUL R2,R3 with three wait cycles in T1.
    cu_if.mem_ready = 1'b0; cu_if.IR = {5'b01111, 4'd2, 4'd3, 19'd0};
    tick(); chk("wait_c1_pcin", cu_if.PCin, 1);
    tick(); chk("wait_c2_pcin", cu_if.PCin, 0); chk("wait_c2_read", cu_if.read, 1);
    tick(); chk("wait_c3_mdrin", cu_if.MDRin, 1);
    tick(); chk("wait_c4", dut_strb, M_ZLOWOUT | M_READ | M_MDRIN);
    cu_if.mem_ready = 1'b1;
    tick(); chk("mul_t2", cu_if.IRin, 1);
    tick(); chk("mul_t3_rout", cu_if.Rout, 16'h0004);
    tick(); chk("mul_t4_rout", cu_if.Rout, 16'h0008);
            chk("mul_t4_strb", dut_strb, M_ZLOWIN | M_ZHIGHIN);
            chk("mul_t4_alu", cu_if.ALU, 5'b01111);
    tick(); chk("mul_t5_loin", cu_if.LOin, 1);
    tick(); chk("mul_t6_hiin", cu_if.HIin, 1);
    tick(); chk("mul_next_t0", cu_if.PCout, 1);

    // ADD R1,R2,R3 with Run dropped for two cycles in T4.
    cu_if.IR = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    ticks(3); chk("add_t3_rout", cu_if.Rout, 16'h0004);
    tick(); cu_if.Run = 1'b0; #1;
    chk("pause1_strb", dut_strb, 0); chk("pause1_rout", cu_if.Rout, 0);
    chk("pause1_alu_hold", cu_if.ALU, 5'b01111);
    tick(); chk("pause2_strb", dut_strb, 0);
    tick(); cu_if.Run = 1'b1; #1;
    chk("resume_t4_rout", cu_if.Rout, 16'h0008); chk("resume_t4_alu", cu_if.ALU, 5'b00011);
    tick(); chk("resume_t5_rin", cu_if.Rin, 16'h0002);
    tick(); chk("resume_t0", cu_if.PCout, 1);

    // Clear during T5 of the same ADD.
    ticks(5); chk("pre_clr_t5_rin", cu_if.Rin, 16'h0002);
    clear = 1'b0; #1;
    chk("clr_t5_no_rin", cu_if.Rin, 0);
    tick(); clear = 1'b1; #1;
    chk("clr_t0_strb", dut_strb, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN);
    chk("clr_alu", cu_if.ALU, 0); chk("clr_halted", cu_if.halted, 0);

    // HALT, then release by a one-cycle clear.
    cu_if.IR = {HALT_OP, 27'd0};
    ticks(3); chk("halt_t3_strb", dut_strb, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_halted", cu_if.halted, 1);
      chk("halt_strb", dut_strb, 0);
      tick();
    end
    clear = 1'b0;
    tick(); clear = 1'b1; #1;
    chk("unhalt_halted", cu_if.halted, 0); chk("unhalt_t0", cu_if.PCout, 1);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      clear           = ($urandom_range(0, 59) != 0);
      cu_if.Run       = ($urandom_range(0, 3) != 0);
      cu_if.mem_ready = ($urandom_range(0, 2) != 0);
      rnd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rop = 5'($urandom_range(0, 12));
        5, 6:          rop = ($urandom_range(0, 1) != 0) ? 5'b01111 : 5'b10000;
        7:             rop = HALT_OP;
        default:       rop = 5'($urandom_range(0, 31));
      endcase
      cu_if.IR = {rop, rnd[26:0]};
    end
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
